// File: rtl/tutorial_pkg.sv
// Shared definitions for the lab-0 switch-to-LED self-test: state encoding,
// LED width and the golden LED function used by RTL and checker alike.
package tutorial_pkg;

    localparam int LED_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_t;

    function automatic logic [LED_W-1:0] expected_led(input logic [LED_W-1:0] s);
        logic [LED_W-1:0] led;
        led[0]   = ~s[0];
        led[1]   = s[1] & ~s[2];
        led[3]   = s[2] & s[3];
        led[2]   = led[1] | led[3];
        led[7:4] = s[7:4];
        return led;
    endfunction

endpackage

// File: rtl/tutorial_bist_scoreboard.sv
// Compares returned LED words against the golden function and keeps the
// saturating error count plus the first failing vector.
module tutorial_bist_scoreboard
    import tutorial_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             check_en,
    input  logic [LED_W-1:0] vec,
    input  logic [LED_W-1:0] dut_led,
    output logic [7:0]       err_cnt,
    output logic [LED_W-1:0] first_fail,
    output logic             fail_vld
);

    logic w_mismatch;

    assign w_mismatch = (dut_led != expected_led(vec));

    // Result registers; clear wins over a compare in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt    <= 8'd0;
            first_fail <= 8'd0;
            fail_vld   <= 1'b0;
        end else if (clear) begin
            err_cnt    <= 8'd0;
            first_fail <= 8'd0;
            fail_vld   <= 1'b0;
        end else if (check_en && w_mismatch) begin
            if (err_cnt != 8'd255) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (!fail_vld) begin
                first_fail <= vec;
                fail_vld   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tutorial_bist.sv
// Self-test controller for the switch-to-LED block: sweeps vectors into the
// block, checks each LED word, and passes board switches through when idle.
module tutorial_bist
    import tutorial_pkg::*;
#(
    parameter int SETTLE = 4,
    parameter int STEP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LED_W-1:0] swt_in,
    input  logic [LED_W-1:0] dut_led,
    output logic [LED_W-1:0] dut_swt,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_cnt,
    output logic [LED_W-1:0] first_fail,
    output logic             fail_vld
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);
    localparam logic [8:0] STEP_W   = 9'(STEP);

    bist_state_t      r_state;
    bist_state_t      w_next;
    logic [LED_W-1:0] r_vec;
    logic [LED_W-1:0] r_dut_swt;
    logic [3:0]       r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             w_launch;
    logic             w_check;
    logic [8:0]       w_sum;
    logic [7:0]       w_err_cnt;

    assign w_launch = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_check  = (r_state == ST_CHECK);
    // Bit 8 of the sum marks the sweep running off the top of the vector space
    assign w_sum    = {1'b0, r_vec} + STEP_W;

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_SETTLE;
                else       w_next = ST_IDLE;
            end
            ST_SETTLE: begin
                if (r_cnt == CNT_LAST) w_next = ST_CHECK;
                else                   w_next = ST_SETTLE;
            end
            ST_CHECK: begin
                if (w_sum[8]) w_next = ST_DONE;
                else          w_next = ST_SETTLE;
            end
            ST_DONE: begin
                if (start) w_next = ST_SETTLE;
                else       w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, vector, settle counter and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_vec     <= 8'd0;
            r_dut_swt <= 8'd0;
            r_cnt     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_SETTLE) || (w_next == ST_CHECK);
            r_done  <= (w_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_vec     <= 8'd0;
                        r_dut_swt <= 8'd0;
                        r_cnt     <= 4'd0;
                    end else begin
                        r_dut_swt <= swt_in;
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                end
                ST_CHECK: begin
                    if (!w_sum[8]) begin
                        r_vec     <= w_sum[7:0];
                        r_dut_swt <= w_sum[7:0];
                        r_cnt     <= 4'd0;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_vec     <= 8'd0;
                        r_dut_swt <= 8'd0;
                        r_cnt     <= 4'd0;
                    end
                end
                default: begin
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    tutorial_bist_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_launch),
        .check_en   (w_check),
        .vec        (r_vec),
        .dut_led    (dut_led),
        .err_cnt    (w_err_cnt),
        .first_fail (first_fail),
        .fail_vld   (fail_vld)
    );

    assign dut_swt = r_dut_swt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err_cnt = w_err_cnt;
    assign pass    = r_done && (w_err_cnt == 8'd0);

endmodule

// File: tb/tb_tutorial_bist.sv
// Self-checking bench for tutorial_bist: a behavioural switch-to-LED model
// with injectable faults, and a queue of expected sweep results.
module tb_tutorial_bist;

    typedef struct {
        int         cycles;
        logic [7:0] err;
        logic [7:0] ff;
        logic       fv;
        logic       ps;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   mode  = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] swt_in = 8'h00;
    logic [7:0] dut_led, dut_swt, err_cnt, first_fail;
    logic       busy, done, pass, fail_vld;
    logic [7:0] dut_led1, dut_swt1, err_cnt1, first_fail1;
    logic       busy1, done1, pass1, fail_vld1;

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_led(input logic [7:0] s);
        logic [7:0] l;
        l = {s[7:4], s[2] & s[3], (s[1] & ~s[2]) | (s[2] & s[3]), s[1] & ~s[2], ~s[0]};
        return l;
    endfunction

    function automatic logic [7:0] led_model(input logic [7:0] s, input int m);
        logic [7:0] l;
        l = ref_led(s);
        case (m)
            1: l = l & 8'hFE;
            2: if (s == 8'h0E) l = l ^ 8'h08;
            3: l = ~l;
            default: ;
        endcase
        return l;
    endfunction

    always_comb dut_led  = led_model(dut_swt, mode);
    always_comb dut_led1 = led_model(dut_swt1, 3);

    tutorial_bist dut (
        .clk(clk), .rst(rst), .start(start), .swt_in(swt_in), .dut_led(dut_led),
        .dut_swt(dut_swt), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail(first_fail), .fail_vld(fail_vld)
    );

    tutorial_bist #(.SETTLE(4), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .swt_in(swt_in), .dut_led(dut_led1),
        .dut_swt(dut_swt1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err_cnt1), .first_fail(first_fail1), .fail_vld(fail_vld1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_and_check(input string name, input int m, input logic [7:0] e,
                                 input logic [7:0] f, input logic v, input logic p,
                                 input logic b);
        exp_t x;
        if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        x = exp_q.pop_front();
        n_vec++;
        if (m !== x.cycles) begin n_bad++; $display("FAIL %s cycles: got %0d want %0d", name, m, x.cycles); end
        n_vec++;
        if (e !== x.err) begin n_bad++; $display("FAIL %s err_cnt: got %0d want %0d", name, e, x.err); end
        n_vec++;
        if (v !== x.fv) begin n_bad++; $display("FAIL %s fail_vld: got %b want %b", name, v, x.fv); end
        n_vec++;
        if (x.fv && f !== x.ff) begin n_bad++; $display("FAIL %s first_fail: got %h want %h", name, f, x.ff); end
        n_vec++;
        if (p !== x.ps) begin n_bad++; $display("FAIL %s pass: got %b want %b", name, p, x.ps); end
        n_vec++;
        if (b !== 1'b0) begin n_bad++; $display("FAIL %s busy at done: got %b want 0", name, b); end
    endtask

    // Sweep on the default instance; optionally pokes start mid-sweep.
    task automatic run_sweep(input string name, input int m_mode, input exp_t e, input bit poke);
        int m;
        mode = m_mode;
        exp_q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        m = 0;
        n_vec++;
        if (busy !== 1'b1 || dut_swt !== 8'h00) begin
            n_bad++; $display("FAIL %s launch: busy=%b swt=%h want 1/00", name, busy, dut_swt);
        end
        while (done !== 1'b1 && m < 800) begin
            if (poke && m == 22) start = 1'b1;
            tick();
            start = 1'b0;
            m++;
            if (done !== 1'b1 && (m % 5) == 0) begin
                n_vec++;
                if (dut_swt !== 8'((m / 5) * 2)) begin
                    n_bad++; $display("FAIL %s vector: got %h want %h", name, dut_swt, 8'((m / 5) * 2));
                end
            end
        end
        if (done !== 1'b1) $display("FAIL %s timeout: done=%b want 1", name, done);
        pop_and_check(name, m, err_cnt, first_fail, fail_vld, pass, busy);
    endtask

    task automatic test_reset();
        #3;
        n_vec++;
        if ({busy, done, pass, fail_vld, err_cnt, first_fail, dut_swt} !== 28'd0) begin
            n_bad++; $display("FAIL reset: outputs=%h want 0", {busy, done, pass, fail_vld, err_cnt, first_fail, dut_swt});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_pass_through();
        swt_in = 8'hA5;
        #1;
        n_vec++;
        if (dut_swt !== 8'h00) begin n_bad++; $display("FAIL passthru early: got %h want 00", dut_swt); end
        tick();
        n_vec++;
        if (dut_swt !== 8'hA5) begin n_bad++; $display("FAIL passthru: got %h want A5", dut_swt); end
        swt_in = 8'h3C;
        tick();
        n_vec++;
        if (dut_swt !== 8'h3C) begin n_bad++; $display("FAIL passthru2: got %h want 3C", dut_swt); end
        repeat (6) tick();
    endtask

    task automatic test_done_hold();
        swt_in = 8'h11;
        repeat (3) tick();
        n_vec++;
        if (dut_swt !== 8'hFE || done !== 1'b1) begin
            n_bad++; $display("FAIL done_hold: swt=%h done=%b want FE/1", dut_swt, done);
        end
    endtask

    task automatic test_step1();
        exp_t e;
        int m;
        e = '{cycles: 1280, err: 8'd255, ff: 8'h00, fv: 1'b1, ps: 1'b0};
        exp_q.push_back(e);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        m = 0;
        while (done1 !== 1'b1 && m < 1500) begin
            tick();
            m++;
        end
        if (done1 !== 1'b1) $display("FAIL step1 timeout: done=%b want 1", done1);
        pop_and_check("step1", m, err_cnt1, first_fail1, fail_vld1, pass1, busy1);
    endtask

    task automatic test_reset_mid_sweep();
        int m;
        exp_t e;
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        m = 0;
        while (dut_swt !== 8'h40 && m < 400) begin tick(); m++; end
        n_vec++;
        if (err_cnt !== 8'd32 || fail_vld !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset: err=%0d fv=%b want 32/1", err_cnt, fail_vld);
        end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || dut_swt !== 8'h00 || err_cnt !== 8'h00 || fail_vld !== 1'b0) begin
            n_bad++; $display("FAIL async_reset: busy=%b swt=%h err=%0d fv=%b want 0", busy, dut_swt, err_cnt, fail_vld);
        end
        #1 rst = 1'b0;
        swt_in = 8'h5A;
        tick();
        n_vec++;
        if (dut_swt !== 8'h5A) begin n_bad++; $display("FAIL post_reset passthru: got %h want 5A", dut_swt); end
        e = '{cycles: 640, err: 8'd0, ff: 8'h00, fv: 1'b0, ps: 1'b1};
        run_sweep("after_reset", 0, e, 1'b0);
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        tick();
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0 || dut_swt !== 8'h00) begin
            n_bad++; $display("FAIL restart: busy=%b done=%b swt=%h want 1/0/00", busy, done, dut_swt);
        end
        repeat (660) tick();
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL held_start: busy=%b done=%b want 1/0", busy, done);
        end
        start = 1'b0;
    endtask

    initial begin
        exp_t e;
        test_reset();
        test_pass_through();
        e = '{cycles: 640, err: 8'd0, ff: 8'h00, fv: 1'b0, ps: 1'b1};
        run_sweep("clean", 0, e, 1'b0);
        test_done_hold();
        e = '{cycles: 640, err: 8'd128, ff: 8'h00, fv: 1'b1, ps: 1'b0};
        run_sweep("led0_stuck", 1, e, 1'b0);
        e = '{cycles: 640, err: 8'd1, ff: 8'h0E, fv: 1'b1, ps: 1'b0};
        run_sweep("single_fault", 2, e, 1'b0);
        e = '{cycles: 640, err: 8'd0, ff: 8'h00, fv: 1'b0, ps: 1'b1};
        run_sweep("start_while_busy", 0, e, 1'b1);
        test_step1();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/tutorial_bist.md
# tutorial_bist

Built-in self-test controller for the lab-0 switch-to-LED logic block. It owns the block's 8-bit switch input and sweeps a vector set into it, waiting a settle interval before each check. Each resulting LED word is compared against the golden LED function, and the controller reports error count, first failing vector and pass/fail. When idle it passes the board switches through, so the logic stays usable by hand between self-tests.

## Interface
- `SETTLE`, default 4: cycles a vector is held before its LED word is sampled; legal range 1..15.
- `STEP`, default 2: vector increment; legal range 1..128.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `start`  in  1  launches a sweep when sampled high in IDLE or DONE; ignored otherwise.
- `swt_in`  in  8  board switches, passed through while not testing.
- `dut_led`  in  8  LED word returned by the switch-to-LED logic.
- `dut_swt`  out  8  registered switch word driven into the switch-to-LED logic.
- `busy`  out  1  high in SETTLE and CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `err_cnt` is 0.
- `err_cnt`  out  8  mismatch count; saturates at 255.
- `first_fail`  out  8  first mismatching vector; valid only when `fail_vld` is high.
- `fail_vld`  out  1  at least one mismatch since the sweep started.

## Operation
- Reset values: state IDLE, `dut_swt`=0, `busy`=`done`=`pass`=`fail_vld`=0, `err_cnt`=0, `first_fail`=0, vector register=0, settle counter=0.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - `dut_swt` <= `swt_in` every cycle, registered, so it follows the switches with one cycle of delay.
  - `start` -> SETTLE. On the same edge: vec=0, `dut_swt`=0, `err_cnt`=0, `fail_vld`=0, `first_fail`=0, settle counter=0.
- SETTLE:
  - Counter increments each cycle.
  - When the counter reaches SETTLE-1, the next state is CHECK.
  - `dut_swt` holds vec.
- CHECK (exactly one cycle):
  - Sample `dut_led` and compare with `expected_led(vec)`.
  - On mismatch: `err_cnt` increments, saturating at 255. If `fail_vld` is 0, set `first_fail`=vec and `fail_vld`=1.
  - Compute the 9-bit sum vec+STEP. If bit 8 is set -> DONE. Otherwise vec=sum[7:0], `dut_swt`=sum[7:0], counter=0, next state SETTLE.
- DONE:
  - `done`=1; `pass`=(`err_cnt`==0).
  - `dut_swt` holds the last vector; no pass-through. Results hold.
  - `start` -> restart exactly as from IDLE. There is no return to IDLE except through reset.
- Golden function `expected_led(s)`:
  - led[0]=~s[0]
  - led[1]=s[1]&~s[2]
  - led[3]=s[2]&s[3]
  - led[2]=led[1]|led[3]
  - led[7:4]=s[7:4]
- Vector count NV = floor(255/STEP)+1. With STEP=2: 128 vectors, 0x00..0xFE, last vector 0xFE.

## Timing
- `start` is sampled at edge k. `busy` rises after edge k and `dut_swt`=0 is presented after edge k.
- Each vector occupies SETTLE+1 cycles. The first compare happens at edge k+SETTLE+1.
- `done` rises after edge k+NV·(SETTLE+1), on the same edge that `busy` falls. `err_cnt`, `first_fail` and `fail_vld` are final on that edge.
- Defaults: 128·5 = 640 cycles from start to done.
- `start` held high continuously: restarts one cycle after each DONE entry; no lockup.
- `start` during SETTLE or CHECK: no effect.
- `rst` asserted mid-sweep: immediate return to IDLE with all reset values, with no clock edge needed. Pass-through resumes on the first edge after `rst` deasserts.
- Last-vector mismatch: counted on the same edge DONE is entered.

## Structure
- Package `tutorial_pkg`:
  - function `expected_led`
  - state encoding constants: IDLE=2'd0, SETTLE=2'd1, CHECK=2'd2, DONE=2'd3
  - `LED_W`=8
- The package function is shared with the lab-0 bench's checker so that both use one golden model.
- One natural sub-module: `tutorial_bist_scoreboard`. It owns the compare, the saturating `err_cnt`, `first_fail` and `fail_vld`, and takes `clear`, `check_en`, `vec` and `dut_led` as inputs.
- FSM, vector register and settle counter live in the top.

## Test plan
- Correct switch-to-LED logic, defaults, `start` pulsed at cycle 10 -> `done` rises exactly 640 cycles later with `pass`=1, `err_cnt`=0, `fail_vld`=0.
- `dut_led[0]` forced to 0 -> every even vector mismatches, so `err_cnt`=128, `first_fail`=0x00, `pass`=0.
- `dut_led[3]` inverted only when `dut_swt`=0x0E -> `err_cnt`=1, `first_fail`=0x0E.
- STEP=1, `dut_led` forced to ~expected -> 256 mismatches, `err_cnt` saturates at 255, `first_fail`=0x00, `done` after 256·5 cycles.
- Idle pass-through:
  - `swt_in`=0xA5 -> `dut_swt`=0xA5 one cycle later.
  - `start` pulsed while `busy` -> no restart; vector sequence unbroken.
- `rst` pulsed while vec=0x40 -> `busy`, `dut_swt`, `err_cnt` and `fail_vld` read 0 before the next edge. A following `start` -> full 640-cycle sweep with `pass`=1.
